vector_lane_regfile: RTL and testbench

VECTOR_LANE_REGFILE -- requirements
Module: vector_lane_regfile

---
 rtl/vector_lane_regfile_pkg.sv | 26 ++
 rtl/vrf_lane_mux.sv | 24 ++
 rtl/vector_lane_regfile.sv | 136 +++++++++++++
 tb/tb_vector_lane_regfile.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/vector_lane_regfile_pkg.sv
// Shared types and defaults for the vector lane register file.
package vector_lane_regfile_pkg;

    localparam int unsigned VRF_NUM_REGS = 32;
    localparam int unsigned VRF_LANES    = 4;
    localparam int unsigned VRF_LANE_W   = 32;
    localparam int unsigned VRF_VEC_W    = VRF_LANES * VRF_LANE_W;
    localparam int unsigned VRF_AW       = $clog2(VRF_NUM_REGS);
    localparam int unsigned VRF_LIW      = $clog2(VRF_LANES);

    // Vector register and index types at the default geometry
    typedef logic [VRF_VEC_W-1:0] vrf_vec_t;
    typedef logic [VRF_AW-1:0]    vrf_reg_idx_t;

    // Lane-level types at the default geometry
    typedef logic [VRF_LANE_W-1:0] vrf_lane_t;
    typedef logic [VRF_LANES-1:0]  vrf_lane_mask_t;
    typedef logic [VRF_LIW-1:0]    vrf_lane_idx_t;

    // Clear sequencer states
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } vrf_state_e;

endpackage

// File: rtl/vrf_lane_mux.sv
// Per-lane masked merge: lanes with mask set take the new word, others keep the old.
module vrf_lane_mux
    import vector_lane_regfile_pkg::*;
#(
    parameter int unsigned LANES  = VRF_LANES,
    parameter int unsigned LANE_W = VRF_LANE_W
) (
    input  logic [LANES*LANE_W-1:0] i_old,
    input  logic [LANES*LANE_W-1:0] i_new,
    input  logic [LANES-1:0]        i_mask,
    output logic [LANES*LANE_W-1:0] o_merged_c
);

    // Lane-by-lane select between old and new data
    always_comb begin
        o_merged_c = i_old;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (i_mask[i]) begin
                o_merged_c[i*LANE_W +: LANE_W] = i_new[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/vector_lane_regfile.sv
// Vector register file with masked lane writes, two registered read ports,
// scalar lane extract on port A, and a one-register-per-cycle clear sequencer.
// Optional feature macro: VRF_BYPASS_EN (same-cycle write-to-read forwarding).
module vector_lane_regfile
    import vector_lane_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = VRF_NUM_REGS,
    parameter int unsigned LANES    = VRF_LANES,
    parameter int unsigned LANE_W   = VRF_LANE_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(NUM_REGS)-1:0]  rd_addr_a,
    input  logic [$clog2(NUM_REGS)-1:0]  rd_addr_b,
    output logic [LANES*LANE_W-1:0]      rd_data_a,
    output logic [LANES*LANE_W-1:0]      rd_data_b,
    input  logic [$clog2(LANES)-1:0]     rd_lane_idx,
    output logic [LANE_W-1:0]            rd_lane_data,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]  wr_addr,
    input  logic [LANES-1:0]             wr_mask,
    input  logic [LANES*LANE_W-1:0]      wr_data,
    input  logic                         clr_req,
    output logic                         busy
);

    localparam int unsigned VEC_W = LANES * LANE_W;
    localparam int unsigned AW    = $clog2(NUM_REGS);

    vrf_state_e        r_state;
    logic [AW-1:0]     r_clr_cnt;
    logic              r_busy;
    logic [VEC_W-1:0]  r_mem [NUM_REGS];
    logic [VEC_W-1:0]  r_rd_data_a;
    logic [VEC_W-1:0]  r_rd_data_b;
    logic [LANE_W-1:0] r_rd_lane;

    logic              w_wr_accept;
    logic              w_clr_last;
    logic [VEC_W-1:0]  w_wr_merged;
    logic [VEC_W-1:0]  w_rd_a_next;
    logic [VEC_W-1:0]  w_rd_b_next;
    logic [LANE_W-1:0] w_rd_lane_next;

    // A write lands only in IDLE, loses to a same-cycle clear, and is a no-op with an empty mask
    assign w_wr_accept = wr_en && (r_state == ST_IDLE) && !clr_req && (|wr_mask);
    assign w_clr_last  = (r_clr_cnt == AW'(NUM_REGS - 1));

    // Shared merge of the target register with incoming lanes (write path and forwarding)
    vrf_lane_mux #(
        .LANES  (LANES),
        .LANE_W (LANE_W)
    ) u_wr_mux (
        .i_old      (r_mem[wr_addr]),
        .i_new      (wr_data),
        .i_mask     (wr_mask),
        .o_merged_c (w_wr_merged)
    );

`ifdef VRF_BYPASS_EN
    // Forward the merged write to a read of the same register in the same cycle
    assign w_rd_a_next = (w_wr_accept && (rd_addr_a == wr_addr)) ? w_wr_merged : r_mem[rd_addr_a];
    assign w_rd_b_next = (w_wr_accept && (rd_addr_b == wr_addr)) ? w_wr_merged : r_mem[rd_addr_b];
`else
    // Reads see pre-write contents; a same-cycle write shows up one cycle later
    assign w_rd_a_next = r_mem[rd_addr_a];
    assign w_rd_b_next = r_mem[rd_addr_b];
`endif

    assign w_rd_lane_next = w_rd_a_next[32'(rd_lane_idx)*LANE_W +: LANE_W];

    // Clear sequencer: IDLE -> CLEAR on request, one register per cycle, back after the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (w_clr_last) begin
                        r_state   <= ST_IDLE;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + AW'(1);
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    // Register array: clear step has priority, otherwise accepted masked write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr_accept) begin
            r_mem[wr_addr] <= w_wr_merged;
        end
    end

    // Registered read ports and lane extract
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
            r_rd_lane   <= '0;
        end else begin
            r_rd_data_a <= w_rd_a_next;
            r_rd_data_b <= w_rd_b_next;
            r_rd_lane   <= w_rd_lane_next;
        end
    end

    assign rd_data_a    = r_rd_data_a;
    assign rd_data_b    = r_rd_data_b;
    assign rd_lane_data = r_rd_lane;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vector_lane_regfile.sv
// Directed self-checking bench for vector_lane_regfile at default geometry.
module tb_vector_lane_regfile;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned LANES    = 4;
    localparam int unsigned LANE_W   = 32;
    localparam int unsigned VEC_W    = LANES * LANE_W;

    logic              clk;
    logic              rst_n;
    logic [4:0]        rd_addr_a;
    logic [4:0]        rd_addr_b;
    logic [VEC_W-1:0]  rd_data_a;
    logic [VEC_W-1:0]  rd_data_b;
    logic [1:0]        rd_lane_idx;
    logic [LANE_W-1:0] rd_lane_data;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [3:0]        wr_mask;
    logic [VEC_W-1:0]  wr_data;
    logic              clr_req;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    vector_lane_regfile #(
        .NUM_REGS (NUM_REGS),
        .LANES    (LANES),
        .LANE_W   (LANE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .rd_data_a    (rd_data_a),
        .rd_data_b    (rd_data_b),
        .rd_lane_idx  (rd_lane_idx),
        .rd_lane_data (rd_lane_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_mask      (wr_mask),
        .wr_data      (wr_data),
        .clr_req      (clr_req),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wr_en   = 1'b0;
        wr_mask = 4'b0000;
        wr_data = '0;
        wr_addr = '0;
        clr_req = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] addr, input logic [VEC_W-1:0] data, input logic [3:0] mask);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_mask = mask;
        step();
        idle_inputs();
    endtask

    function automatic logic [VEC_W-1:0] fill_val(input int unsigned idx);
        logic [LANE_W-1:0] w;
        w = 32'h1000_0000 + 32'(idx);
        return {w, w, w, w};
    endfunction

    logic [VEC_W-1:0] exp_v;
    int busy_cnt;
    int guard;

    initial begin
        rst_n       = 1'b0;
        rd_addr_a   = '0;
        rd_addr_b   = '0;
        rd_lane_idx = '0;
        idle_inputs();

        // Reset state
        #12;
        check("rst_busy", VEC_W'(busy), '0);
        check("rst_rda", rd_data_a, '0);
        check("rst_lane", VEC_W'(rd_lane_data), '0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_addr_a = 5'd0;
        rd_addr_b = 5'd31;
        step();
        check("r0_a", rd_data_a, '0);
        check("r31_b", rd_data_b, '0);
        check("idle_busy", VEC_W'(busy), '0);

        // Full write then partial masked overwrite of r5
        write_reg(5'd5, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 4'b1111);
        write_reg(5'd5, {4{32'hFFFF_FFFF}}, 4'b0101);
        rd_addr_a   = 5'd5;
        rd_addr_b   = 5'd5;
        rd_lane_idx = 2'd2;
        step();
        exp_v = {32'h4444_4444, 32'hFFFF_FFFF, 32'h2222_2222, 32'hFFFF_FFFF};
        check("mask_a", rd_data_a, exp_v);
        check("mask_b", rd_data_b, exp_v);
        check("lane2", VEC_W'(rd_lane_data), VEC_W'(32'hFFFF_FFFF));
        rd_lane_idx = 2'd1;
        step();
        check("lane1", VEC_W'(rd_lane_data), VEC_W'(32'h2222_2222));

        // Empty mask changes nothing
        write_reg(5'd5, {4{32'h0BAD_0BAD}}, 4'b0000);
        step();
        check("mask0_a", rd_data_a, exp_v);

        // Same-cycle write and read of r7
        rd_addr_a   = 5'd7;
        rd_addr_b   = 5'd7;
        rd_lane_idx = 2'd3;
        write_reg(5'd7, {4{32'hA5A5_A5A5}}, 4'b1111);
`ifdef VRF_BYPASS_EN
        exp_v = {4{32'hA5A5_A5A5}};
`else
        exp_v = '0;
`endif
        check("byp_a", rd_data_a, exp_v);
        check("byp_b", rd_data_b, exp_v);
        check("byp_lane", VEC_W'(rd_lane_data), VEC_W'(exp_v[LANE_W-1:0]));
        step();
        check("r7_next", rd_data_a, {4{32'hA5A5_A5A5}});

        // Fill all registers with nonzero data
        for (int i = 0; i < 32; i++) begin
            write_reg(5'(i), fill_val(32'(i)), 4'b1111);
        end
        rd_addr_a = 5'd3;
        step();
        check("fill_r3", rd_data_a, fill_val(3));

        // Clear with a competing write to r3 in the same cycle
        clr_req = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_mask = 4'b1111;
        wr_data = {4{32'h3333_CAFE}};
        step();
        idle_inputs();
        busy_cnt = 0;
        guard    = 0;
        while (busy && guard < 100) begin
            busy_cnt++;
            guard++;
            idle_inputs();
            if (busy_cnt == 1) rd_addr_a = 5'd31;
            if (busy_cnt == 2) check("clr_rd_old", rd_data_a, fill_val(31));
            if (busy_cnt == 5) clr_req = 1'b1;
            if (busy_cnt == 10) begin
                wr_en   = 1'b1;
                wr_addr = 5'd0;
                wr_mask = 4'b1111;
                wr_data = {4{32'hDEAD_BEEF}};
            end
            step();
        end
        idle_inputs();
        check("busy_len", VEC_W'(busy_cnt), VEC_W'(32));
        for (int i = 0; i < 32; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(31 - i);
            step();
            check($sformatf("clr_a%0d", i), rd_data_a, '0);
            check($sformatf("clr_b%0d", 31 - i), rd_data_b, '0);
        end

        // Reset in the middle of a clear
        write_reg(5'd2, fill_val(2), 4'b1111);
        write_reg(5'd29, fill_val(29), 4'b1111);
        rd_addr_a = 5'd29;
        step();
        check("pre_r29", rd_data_a, fill_val(29));
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 1;
        guard    = 0;
        while (busy_cnt < 10 && guard < 100) begin
            guard++;
            step();
            busy_cnt++;
        end
        check("mid_busy", VEC_W'(busy), VEC_W'(1));
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", VEC_W'(busy), '0);
        check("rst_mid_rda", rd_data_a, '0);
        step();
        rst_n = 1'b1;
        rd_addr_a = 5'd2;
        rd_addr_b = 5'd29;
        step();
        check("post_r2", rd_data_a, '0);
        check("post_r29", rd_data_b, '0);
        check("post_busy", VEC_W'(busy), '0);
        write_reg(5'd9, {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001}, 4'b1111);
        rd_addr_a   = 5'd9;
        rd_lane_idx = 2'd0;
        step();
        check("post_wr", rd_data_a, {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001});
        check("post_lane0", VEC_W'(rd_lane_data), VEC_W'(32'h0000_0001));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
